// File: rtl/mips_mem_pkg.sv
// Shared types for the MIPS unified-memory arbiter: memory modes, FSM states
// and the access alignment rule.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        MW_NONE = 2'b00,
        MW_BYTE = 2'b01,
        MW_HALF = 2'b10,
        MW_WORD = 2'b11
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_BUSY_I = 2'b01,
        ST_BUSY_D = 2'b10
    } arb_state_e;

    // Reads (MW_NONE) are always full words, so they share the word rule.
    function automatic logic is_misaligned(input logic [1:0] mode, input logic [1:0] a);
        case (mode)
            MW_BYTE: return 1'b0;
            MW_HALF: return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Requester (IF, data) and memory-side signals of the arbiter, with the
// arbiter seen as slave and the surrounding system as master.
interface mips_mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req;
    logic [1:0]  d_memwrite;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_memwrite;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        err_misalign;
    logic        err_timeout;

    modport slave (
        input  if_req, if_addr, d_req, d_memwrite, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, d_rdata, d_ready, mem_valid, mem_addr, mem_wdata,
               mem_memwrite, err_misalign, err_timeout
    );

    modport master (
        output if_req, if_addr, d_req, d_memwrite, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, d_rdata, d_ready, mem_valid, mem_addr, mem_wdata,
               mem_memwrite, err_misalign, err_timeout
    );
endinterface

// File: rtl/mips_mem_arbiter_timeout_cnt.sv
// Ack wait counter: counts cycles while enabled, expire flags the last
// permitted cycle of an access without ack.
module mem_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_start,
    output logic o_expire
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_start && r_cnt != LAST)
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_expire = i_start && (r_cnt == LAST);
endmodule

// File: rtl/mips_mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data
// access, with alignment checks, ack timeout and IF starvation guard.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int TIMEOUT      = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    mips_mem_arbiter_if.slave  bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_e   r_state, w_state_nxt;
    logic         r_mem_valid;
    logic [31:0]  r_mem_addr, r_mem_wdata;
    mem_mode_e    r_mem_memwrite;
    logic [31:0]  r_if_rdata, r_d_rdata;
    logic         r_if_ready, r_d_ready;
    logic         r_err_mis, r_err_to;
    logic [SW-1:0] r_starve;

    logic w_grant_i, w_grant_d, w_done, w_abort, w_expire;
    logic w_if_mis, w_d_mis, w_if_force, w_hold;

    assign w_if_mis   = is_misaligned(MW_NONE, bus.if_addr[1:0]);
    assign w_d_mis    = is_misaligned(bus.d_memwrite, bus.d_addr[1:0]);
    assign w_if_force = bus.if_req && (r_starve == STARVE_MAX);
    // A ready cycle is a turnaround: the finishing requester still holds its
    // request, so no new grant is issued until the pulse has gone.
    assign w_hold     = r_if_ready | r_d_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_hold) begin
                    if (w_if_force)     w_grant_i = 1'b1;
                    else if (bus.d_req) w_grant_d = 1'b1;
                    else if (bus.if_req) w_grant_i = 1'b1;
                end
                if (w_grant_i && !w_if_mis) w_state_nxt = ST_BUSY_I;
                if (w_grant_d && !w_d_mis)  w_state_nxt = ST_BUSY_D;
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (bus.mem_ack)   w_done  = 1'b1;
                else if (w_expire) w_abort = 1'b1;
                if (w_done || w_abort) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    mem_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
        .i_clk    (clk),
        .i_rst    (reset),
        .i_clear  (w_grant_i | w_grant_d | w_done | w_abort),
        .i_start  (r_mem_valid),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_valid    <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_mem_memwrite <= MW_NONE;
            r_if_rdata     <= '0;
            r_d_rdata      <= '0;
            r_if_ready     <= 1'b0;
            r_d_ready      <= 1'b0;
            r_err_mis      <= 1'b0;
            r_err_to       <= 1'b0;
            r_starve       <= '0;
        end else begin
            r_if_ready <= 1'b0;
            r_d_ready  <= 1'b0;

            if (w_grant_i) begin
                if (w_if_mis) begin
                    r_if_ready <= 1'b1;
                    r_if_rdata <= '0;
                    r_err_mis  <= 1'b1;
                end else begin
                    r_mem_valid    <= 1'b1;
                    r_mem_addr     <= bus.if_addr;
                    r_mem_wdata    <= '0;
                    r_mem_memwrite <= MW_NONE;
                end
            end

            if (w_grant_d) begin
                if (w_d_mis) begin
                    r_d_ready <= 1'b1;
                    r_d_rdata <= '0;
                    r_err_mis <= 1'b1;
                end else begin
                    r_mem_valid    <= 1'b1;
                    r_mem_addr     <= bus.d_addr;
                    r_mem_wdata    <= bus.d_wdata;
                    r_mem_memwrite <= mem_mode_e'(bus.d_memwrite);
                end
            end

            if (w_done || w_abort) begin
                r_mem_valid <= 1'b0;
                if (w_abort) r_err_to <= 1'b1;
                if (r_state == ST_BUSY_I) begin
                    r_if_ready <= 1'b1;
                    r_if_rdata <= w_done ? bus.mem_rdata : 32'h0;
                end else begin
                    r_d_ready <= 1'b1;
                    if (w_abort)
                        r_d_rdata <= '0;
                    else if (r_mem_memwrite == MW_NONE)
                        r_d_rdata <= bus.mem_rdata;
                end
            end

            if (!bus.if_req || w_grant_i)
                r_starve <= '0;
            else if (w_grant_d && r_starve != STARVE_MAX)
                r_starve <= r_starve + 1'b1;
        end
    end

    assign bus.mem_valid    = r_mem_valid;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.mem_memwrite = r_mem_memwrite;
    assign bus.if_rdata     = r_if_rdata;
    assign bus.if_ready     = r_if_ready;
    assign bus.d_rdata      = r_d_rdata;
    assign bus.d_ready      = r_d_ready;
    assign bus.err_misalign = r_err_mis;
    assign bus.err_timeout  = r_err_to;
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter: vector table for single data
// accesses plus hand sequences for contention, timeout and reset.
module tb_mips_mem_arbiter;
    logic clk;
    logic reset;
    mips_mem_arbiter_if bus();

    mips_mem_arbiter #(.TIMEOUT(16), .STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory responder: acks on the first mem_valid cycle when enabled.
    logic        ack_en;
    logic        spur;
    logic [31:0] mem_data;
    initial begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_valid && ack_en) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = mem_data;
            end else if (spur) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = 32'hFFFF_FFFF;
            end else begin
                bus.mem_ack   = 1'b0;
            end
        end
    end

    // Grant log: one entry (mem_addr) per rising mem_valid.
    logic        logging;
    logic        prev_valid;
    logic [31:0] glog[$];
    int          if_pulses;
    initial begin
        prev_valid = 1'b0;
        if_pulses  = 0;
        forever begin
            @(negedge clk);
            if (logging) begin
                if (bus.mem_valid && !prev_valid) glog.push_back(bus.mem_addr);
                if (bus.if_ready) if_pulses++;
            end
            prev_valid = bus.mem_valid;
        end
    end

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mdata;
        int          lat;
        logic [31:0] rdata;
        logic        valid;
        logic        err;
    } vec_t;

    vec_t tv[9];

    task automatic d_access(input logic [1:0] mode, input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rdata, output logic vseen,
                            output logic [31:0] maddr, output logic [31:0] mwdata,
                            output logic [1:0] mmode, output logic pulse_once);
        lat = 40; rdata = 'x; vseen = 1'b0; maddr = 'x; mwdata = 'x; mmode = 'x; pulse_once = 1'b0;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_memwrite = mode; bus.d_addr = addr; bus.d_wdata = wdata;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (bus.mem_valid) begin
                vseen = 1'b1; maddr = bus.mem_addr; mwdata = bus.mem_wdata; mmode = bus.mem_memwrite;
            end
            if (bus.d_ready) begin
                lat = c; rdata = bus.d_rdata;
                break;
            end
        end
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        pulse_once = (lat != 40) && !bus.d_ready;
    endtask

    task automatic if_access(input logic [31:0] addr, output int lat, output int vcnt,
                             output logic [31:0] rdata);
        lat = 60; vcnt = 0; rdata = 'x;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = addr;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (bus.mem_valid) vcnt++;
            if (bus.if_ready) begin
                lat = c; rdata = bus.if_rdata;
                break;
            end
        end
        bus.if_req = 1'b0;
    endtask

    int          lat, vcnt, icnt;
    logic [31:0] rd, ma, mw;
    logic [1:0]  mm;
    logic        vs, po;
    logic        saw_ready;

    initial begin
        // mode, addr, wdata, mem rdata, latency, d_rdata, mem_valid seen, err_misalign
        tv[0] = '{2'b00, 32'd84,   32'h0,    32'd7,         2, 32'd7,         1'b1, 1'b0};
        tv[1] = '{2'b11, 32'd84,   32'd7,    32'hAAAA_AAAA, 2, 32'd7,         1'b1, 1'b0};
        tv[2] = '{2'b01, 32'h87,   32'hAB,   32'hBBBB_BBBB, 2, 32'd7,         1'b1, 1'b0};
        tv[3] = '{2'b10, 32'h86,   32'hBEEF, 32'hCCCC_CCCC, 2, 32'd7,         1'b1, 1'b0};
        tv[4] = '{2'b00, 32'h90,   32'h0,    32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b1, 1'b0};
        tv[5] = '{2'b11, 32'd86,   32'h11,   32'h0,         1, 32'h0,         1'b0, 1'b1};
        tv[6] = '{2'b10, 32'h85,   32'h22,   32'h0,         1, 32'h0,         1'b0, 1'b1};
        tv[7] = '{2'b00, 32'h8A,   32'h0,    32'h0,         1, 32'h0,         1'b0, 1'b1};
        tv[8] = '{2'b00, 32'h94,   32'h0,    32'h55,        2, 32'h55,        1'b1, 1'b1};

        reset = 1'b1; ack_en = 1'b1; spur = 1'b0; mem_data = '0; logging = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_memwrite = 2'b00; bus.d_addr = '0; bus.d_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_valid", {31'b0, bus.mem_valid}, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_ready",     {30'b0, bus.if_ready, bus.d_ready}, 0);
        chk("rst_rdata",     bus.if_rdata | bus.d_rdata, 0);
        chk("rst_err",       {30'b0, bus.err_misalign, bus.err_timeout}, 0);
        @(negedge clk); reset = 1'b0;

        // Single data accesses; latency counts edges from the req sample
        // (req cycle, mem_valid cycle, ready cycle).
        for (int i = 0; i < 9; i++) begin
            mem_data = tv[i].mdata;
            d_access(tv[i].mode, tv[i].addr, tv[i].wdata, lat, rd, vs, ma, mw, mm, po);
            chk($sformatf("v%0d_lat", i),    lat, tv[i].lat);
            chk($sformatf("v%0d_rdata", i),  rd, tv[i].rdata);
            chk($sformatf("v%0d_valid", i),  {31'b0, vs}, {31'b0, tv[i].valid});
            chk($sformatf("v%0d_pulse", i),  {31'b0, po}, 1);
            chk($sformatf("v%0d_errmis", i), {31'b0, bus.err_misalign}, {31'b0, tv[i].err});
            if (tv[i].valid) begin
                chk($sformatf("v%0d_maddr", i), ma, tv[i].addr);
                chk($sformatf("v%0d_mmode", i), {30'b0, mm}, {30'b0, tv[i].mode});
                if (tv[i].mode != 2'b00) chk($sformatf("v%0d_mwdata", i), mw, tv[i].wdata);
            end
        end

        // Contention: both ports held; expect D,D,D,D,I repeating.
        mem_data = 32'h1234;
        glog.delete();
        logging = 1'b1;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.d_req = 1'b1; bus.d_memwrite = 2'b00; bus.d_addr = 32'h200;
        repeat (40) @(negedge clk);
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        repeat (4) @(negedge clk);
        logging = 1'b0;
        chk("grant_count", {31'b0, glog.size() >= 10}, 1);
        if (glog.size() >= 10)
            for (int i = 0; i < 10; i++)
                chk($sformatf("grant_%0d", i), glog[i], (i % 5 == 4) ? 32'h100 : 32'h200);
        icnt = 0;
        foreach (glog[i]) if (glog[i] == 32'h100) icnt++;
        chk("if_not_lost", if_pulses, icnt);
        chk("if_rdata_pre", bus.if_rdata, 32'h1234);
        chk("errto_pre", {31'b0, bus.err_timeout}, 0);

        // Timeout on IF read, then a spurious ack in IDLE.
        ack_en = 1'b0;
        if_access(32'h300, lat, vcnt, rd);
        chk("to_valid_cycles", vcnt, 16);
        chk("to_lat", lat, 17);
        chk("to_if_rdata", rd, 0);
        chk("to_err", {31'b0, bus.err_timeout}, 1);
        chk("to_mem_valid", {31'b0, bus.mem_valid}, 0);
        @(negedge clk); spur = 1'b1;
        repeat (2) @(negedge clk);
        spur = 1'b0;
        @(posedge clk); #1;
        chk("spur_ready", {30'b0, bus.if_ready, bus.d_ready}, 0);
        chk("spur_valid", {31'b0, bus.mem_valid}, 0);
        chk("spur_rdata", bus.if_rdata, 0);
        chk("spur_err", {31'b0, bus.err_timeout}, 1);

        // Reset while a data access is in flight.
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_memwrite = 2'b00; bus.d_addr = 32'h40;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_valid_pre", {31'b0, bus.mem_valid}, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_valid_async", {31'b0, bus.mem_valid}, 0);
        chk("mid_err", {30'b0, bus.err_misalign, bus.err_timeout}, 0);
        bus.d_req = 1'b0;
        saw_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (bus.d_ready) saw_ready = 1'b1;
        end
        @(negedge clk); reset = 1'b0; ack_en = 1'b1;
        @(posedge clk); #1;
        if (bus.d_ready) saw_ready = 1'b1;
        chk("mid_no_ready", {31'b0, saw_ready}, 0);
        mem_data = 32'h99;
        d_access(2'b00, 32'h44, 32'h0, lat, rd, vs, ma, mw, mm, po);
        chk("post_lat", lat, 2);
        chk("post_rdata", rd, 32'h99);
        chk("post_maddr", ma, 32'h44);

        // Misaligned fetch: no memory cycle, ready next cycle, rdata 0.
        if_access(32'h102, lat, vcnt, rd);
        chk("ifmis_lat", lat, 1);
        chk("ifmis_valid", vcnt, 0);
        chk("ifmis_rdata", rd, 0);
        chk("ifmis_err", {31'b0, bus.err_misalign}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
